// File: rtl/can_arb_field_decoder.sv
// CAN arbitration/early-control field decoder: idle/SOF detection,
// bit destuffing, and ID/IDE/RTR/EDL extraction ahead of frame-type decode.
module can_arb_field_decoder #(
  parameter int IDLE_BITS = 11,
  parameter int STUFF_LEN = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sp,
  input  logic        rx_bit,
  output logic [28:0] id,
  output logic        ide,
  output logic        rtr,
  output logic        edl,
  output logic        arb_valid,
  output logic        stuff_err,
  output logic        busy
);

  localparam int CW = $clog2(IDLE_BITS + 1);

  localparam logic [3:0] WAIT_IDLE = 4'd0;
  localparam logic [3:0] IDLE      = 4'd1;
  localparam logic [3:0] BASE_ID   = 4'd2;
  localparam logic [3:0] B12       = 4'd3;
  localparam logic [3:0] IDE_BIT   = 4'd4;
  localparam logic [3:0] FDF_BASE  = 4'd5;
  localparam logic [3:0] EXT_ID    = 4'd6;
  localparam logic [3:0] RTR_EXT   = 4'd7;
  localparam logic [3:0] FDF_EXT   = 4'd8;

  logic [3:0]    state_q, state_d;
  logic [CW-1:0] idle_cnt_q, idle_cnt_d;
  logic [2:0]    run_q, run_d;
  logic          last_q, last_d;
  logic [4:0]    idx_q, idx_d;
  logic [10:0]   base_q, base_d;
  logic [17:0]   ext_q, ext_d;
  logic          b12_q, b12_d;
  logic          rtrx_q, rtrx_d;
  logic [28:0]   id_q, id_d;
  logic          ide_q, ide_d;
  logic          rtr_q, rtr_d;
  logic          edl_q, edl_d;
  logic          arb_valid_q, arb_valid_d;
  logic          stuff_err_q, stuff_err_d;
  logic          busy_q, busy_d;
  logic          data_bit;

  always_comb begin
    state_d     = state_q;
    idle_cnt_d  = idle_cnt_q;
    run_d       = run_q;
    last_d      = last_q;
    idx_d       = idx_q;
    base_d      = base_q;
    ext_d       = ext_q;
    b12_d       = b12_q;
    rtrx_d      = rtrx_q;
    id_d        = id_q;
    ide_d       = ide_q;
    rtr_d       = rtr_q;
    edl_d       = edl_q;
    busy_d      = busy_q;
    arb_valid_d = 1'b0;
    stuff_err_d = 1'b0;
    data_bit    = 1'b0;

    if (sp) begin
      if (state_q == WAIT_IDLE) begin
        if (!rx_bit) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q >= CW'(IDLE_BITS - 1)) begin
          idle_cnt_d = CW'(IDLE_BITS);
          state_d    = IDLE;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end else if (state_q == IDLE) begin
        if (!rx_bit) begin
          state_d    = BASE_ID;
          busy_d     = 1'b1;
          run_d      = 3'd1;
          last_d     = 1'b0;
          idx_d      = '0;
          idle_cnt_d = '0;
        end
      end else if (run_q == 3'(STUFF_LEN)) begin
        // stuff position: must be the complement of the preceding run
        if (rx_bit != last_q) begin
          run_d  = 3'd1;
          last_d = rx_bit;
        end else begin
          stuff_err_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = WAIT_IDLE;
          idle_cnt_d  = '0;
        end
      end else begin
        data_bit = 1'b1;
        if (rx_bit == last_q) begin
          run_d = run_q + 3'd1;
        end else begin
          run_d  = 3'd1;
          last_d = rx_bit;
        end
      end
    end

    if (data_bit) begin
      unique case (state_q)
        BASE_ID: begin
          base_d = {base_q[9:0], rx_bit};
          if (idx_q == 5'd10) begin
            state_d = B12;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
        B12: begin
          b12_d   = rx_bit;
          state_d = IDE_BIT;
        end
        IDE_BIT: begin
          state_d = rx_bit ? EXT_ID : FDF_BASE;
          idx_d   = '0;
        end
        FDF_BASE: begin
          id_d        = {18'd0, base_q};
          ide_d       = 1'b0;
          rtr_d       = b12_q;
          edl_d       = rx_bit;
          arb_valid_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = WAIT_IDLE;
          idle_cnt_d  = '0;
        end
        EXT_ID: begin
          ext_d = {ext_q[16:0], rx_bit};
          if (idx_q == 5'd17) begin
            state_d = RTR_EXT;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
        RTR_EXT: begin
          rtrx_d  = rx_bit;
          state_d = FDF_EXT;
        end
        FDF_EXT: begin
          id_d        = {base_q, ext_q};
          ide_d       = 1'b1;
          rtr_d       = rtrx_q;
          edl_d       = rx_bit;
          arb_valid_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = WAIT_IDLE;
          idle_cnt_d  = '0;
        end
        default: begin
          state_d = WAIT_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= WAIT_IDLE;
      idle_cnt_q  <= '0;
      run_q       <= '0;
      last_q      <= 1'b0;
      idx_q       <= '0;
      base_q      <= '0;
      ext_q       <= '0;
      b12_q       <= 1'b0;
      rtrx_q      <= 1'b0;
      id_q        <= '0;
      ide_q       <= 1'b0;
      rtr_q       <= 1'b0;
      edl_q       <= 1'b0;
      arb_valid_q <= 1'b0;
      stuff_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idle_cnt_q  <= idle_cnt_d;
      run_q       <= run_d;
      last_q      <= last_d;
      idx_q       <= idx_d;
      base_q      <= base_d;
      ext_q       <= ext_d;
      b12_q       <= b12_d;
      rtrx_q      <= rtrx_d;
      id_q        <= id_d;
      ide_q       <= ide_d;
      rtr_q       <= rtr_d;
      edl_q       <= edl_d;
      arb_valid_q <= arb_valid_d;
      stuff_err_q <= stuff_err_d;
      busy_q      <= busy_d;
    end
  end

  assign id        = id_q;
  assign ide       = ide_q;
  assign rtr       = rtr_q;
  assign edl       = edl_q;
  assign arb_valid = arb_valid_q;
  assign stuff_err = stuff_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_can_arb_field_decoder.sv
// Directed bench for can_arb_field_decoder: frames are built unstuffed
// and stuffed on the fly by a small CAN bit-stuffing encoder.
module tb_can_arb_field_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sp = 1'b0;
  logic        rx_bit = 1'b1;
  logic [28:0] id;
  logic        ide, rtr, edl;
  logic        arb_valid, stuff_err, busy;

  int errors = 0;
  int checks = 0;
  int av_cnt = 0;
  int se_cnt = 0;
  int av0, se0;

  can_arb_field_decoder dut (
    .clk       (clk),
    .reset     (reset),
    .sp        (sp),
    .rx_bit    (rx_bit),
    .id        (id),
    .ide       (ide),
    .rtr       (rtr),
    .edl       (edl),
    .arb_valid (arb_valid),
    .stuff_err (stuff_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (arb_valid) av_cnt <= av_cnt + 1;
    if (stuff_err) se_cnt <= se_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // idle gap (sp=0 clocks) before the strobe; returns at the negedge
  // right after the sampling edge, when results are visible
  task automatic send_bit(input logic b, input int maxgap);
    int g;
    g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
    repeat (g) @(negedge clk);
    sp = 1'b1;
    rx_bit = b;
    @(negedge clk);
    sp = 1'b0;
  endtask

  task automatic send_ones(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1, 0);
  endtask

  task automatic send_frame(input logic [63:0] bits, input int n,
                            input int maxgap);
    logic b, last;
    int run;
    run = 0;
    last = 1'b1;
    for (int i = n - 1; i >= 0; i--) begin
      b = bits[i];
      send_bit(b, maxgap);
      if (run != 0 && b == last) run++;
      else begin
        run = 1;
        last = b;
      end
      if (run == 5 && i > 0) begin
        send_bit(~b, maxgap);
        run = 1;
        last = ~b;
      end
    end
  endtask

  task automatic chk_frame(input string tag, input logic [28:0] eid,
                           input logic eide, input logic ertr,
                           input logic eedl);
    chk({tag, "_av"}, 32'(arb_valid), 32'd1);
    chk({tag, "_id"}, 32'(id), 32'(eid));
    chk({tag, "_ide"}, 32'(ide), 32'(eide));
    chk({tag, "_rtr"}, 32'(rtr), 32'(ertr));
    chk({tag, "_edl"}, 32'(edl), 32'(eedl));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    @(negedge clk);
    chk({tag, "_av_off"}, 32'(arb_valid), 32'd0);
    repeat (3) @(negedge clk);
    chk({tag, "_av_cnt"}, 32'(av_cnt - av0), 32'd1);
    chk({tag, "_se_cnt"}, 32'(se_cnt - se0), 32'd0);
  endtask

  logic [63:0] f1, f2, f3;

  initial begin
    f1 = 64'({1'b0, 11'h123, 1'b0, 1'b0, 1'b0});
    f2 = 64'({1'b0, 11'h000, 1'b1, 1'b0, 1'b1});
    f3 = 64'({1'b0, 11'h6AB, 1'b1, 1'b1, 18'h2CDEF, 1'b1, 1'b0});

    repeat (3) @(negedge clk);
    chk("rst_id", 32'(id), 32'd0);
    chk("rst_ide", 32'(ide), 32'd0);
    chk("rst_rtr", 32'(rtr), 32'd0);
    chk("rst_edl", 32'(edl), 32'd0);
    chk("rst_av", 32'(arb_valid), 32'd0);
    chk("rst_se", 32'(stuff_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // base frame 0x123
    send_ones(11);
    av0 = av_cnt; se0 = se_cnt;
    send_frame(f1, 15, 0);
    chk_frame("f1", 29'h123, 1'b0, 1'b0, 1'b0);

    // all-dominant ID with two stuff bits, RTR=1, FDF=1
    send_ones(11);
    av0 = av_cnt; se0 = se_cnt;
    send_frame(f2, 15, 0);
    chk_frame("f2", 29'h0, 1'b0, 1'b1, 1'b1);

    // six dominant in a row: stuff violation
    send_ones(11);
    av0 = av_cnt; se0 = se_cnt;
    for (int i = 0; i < 5; i++) send_bit(1'b0, 0);
    chk("se_busy_pre", 32'(busy), 32'd1);
    send_bit(1'b0, 0);
    chk("se_pulse", 32'(stuff_err), 32'd1);
    chk("se_busy", 32'(busy), 32'd0);
    chk("se_av", 32'(arb_valid), 32'd0);
    chk("se_hold_edl", 32'(edl), 32'd1);
    @(negedge clk);
    chk("se_off", 32'(stuff_err), 32'd0);
    send_bit(1'b0, 0);
    chk("se_no_sof", 32'(busy), 32'd0);
    // ten recessive is not enough
    send_ones(10);
    send_bit(1'b0, 0);
    chk("idle10_no_sof", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    chk("se_cnt", 32'(se_cnt - se0), 32'd1);
    chk("se_av_cnt", 32'(av_cnt - av0), 32'd0);

    // extended frame
    send_ones(11);
    av0 = av_cnt; se0 = se_cnt;
    send_frame(f3, 34, 0);
    chk_frame("f3", {11'h6AB, 18'h2CDEF}, 1'b1, 1'b1, 1'b0);

    // reset in the middle of the base ID
    send_ones(11);
    av0 = av_cnt;
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    chk("mid_busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mr_id", 32'(id), 32'd0);
    chk("mr_ide", 32'(ide), 32'd0);
    chk("mr_rtr", 32'(rtr), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    send_bit(1'b0, 0);
    chk("mr_no_sof", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    chk("mr_av_cnt", 32'(av_cnt - av0), 32'd0);

    // first frame again with random sp spacing
    send_ones(11);
    av0 = av_cnt; se0 = se_cnt;
    send_frame(f1, 15, 3);
    chk_frame("gap", 29'h123, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/can_arb_field_decoder.md
Name: can_arb_field_decoder

Overview:
- Sits directly upstream of the frame-type stage in the CAN decoder.
- Consumes the sampled RX bit stream and performs bus-idle detection, SOF detection and bit destuffing.
- Decodes the arbitration and early control field: base ID, SRR/RTR, IDE, extended ID, RTR, FDF/EDL.
- Presents registered ID, IDE, RTR and EDL with a one-cycle valid strobe. The frame-type stage samples EDL/RTR on that strobe.

Parameters:
- IDLE_BITS, 11: consecutive recessive sampled bits that qualify the bus as idle before an SOF is accepted.
- STUFF_LEN, 5: run length of equal bits after which a stuff bit is expected.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high; clears all state and outputs
- sp  input  1  sample-point strobe, one clk wide; rx_bit is valid when sp=1
- rx_bit  input  1  sampled bus level; 0=dominant, 1=recessive
- id  output  29  decoded identifier; base frames use id[10:0] with id[28:11]=0; extended frames use {base[10:0], ext[17:0]}
- ide  output  1  1=extended format
- rtr  output  1  remote request bit (base: bit after ID; extended: bit after ext ID)
- edl  output  1  FDF/EDL bit (bit after IDE in base format; bit after RTR in extended format)
- arb_valid  output  1  one-clk pulse; id/ide/rtr/edl updated in the same cycle
- stuff_err  output  1  one-clk pulse on stuff rule violation
- busy  output  1  high from accepted SOF until arb_valid or stuff_err

Behaviour:
- State changes only on clk cycles with sp=1, except reset. Cycles with sp=0 hold all state; arb_valid and stuff_err are forced to 0 in those cycles.
- Reset values: id=0, ide=0, rtr=0, edl=0, arb_valid=0, stuff_err=0, busy=0. State=WAIT_IDLE, idle counter=0.
- Reset mid-frame aborts decoding with no arb_valid. The block then requires a fresh IDLE_BITS recessive run before accepting an SOF.
- States:
  - WAIT_IDLE: counts consecutive recessive bits; a dominant bit clears the count. Saturates at IDLE_BITS, then goes to IDLE.
  - IDLE: on a dominant bit, accept SOF, set busy=1, enter BASE_ID. Stuff run = 1, last = 0.
  - BASE_ID: 11 bits, MSB first.
  - B12: captures SRR/RTR.
  - IDE: 0 -> FDF_BASE; 1 -> EXT_ID.
  - FDF_BASE: captures edl. For base format, rtr = B12 bit.
  - EXT_ID: 18 bits, MSB first.
  - RTR_EXT: captures rtr.
  - FDF_EXT: captures edl.
  - After the FDF bit: the next clk registers the outputs and pulses arb_valid. busy drops and the state returns to WAIT_IDLE with idle count 0.
- Latency: arb_valid is high in the clk cycle immediately following the sp cycle that sampled the FDF bit.
- Outputs hold their values until the next arb_valid. They are not cleared on SOF or on a stuff error.
- Destuffing, active from SOF through the FDF bit:
  - Track last bit and run count (3 bits).
  - If run count = STUFF_LEN, the current sampled bit is a stuff bit:
    - If it differs from last: discard it, set run=1 and last=stuff bit. No field bit and no bit index advance.
    - If it equals last: pulse stuff_err in the next clk, drop busy, go to WAIT_IDLE with count 0, no arb_valid.
  - Otherwise the bit is a data bit: if equal to last, run+1; else run=1 and last=bit.
- Bit index counter (5 bits) resets on each field entry and never wraps. Field exits occur at index 10 (base) and 17 (ext).
- A dominant bit in WAIT_IDLE is not an SOF; it only restarts the idle count.
- A stuff bit falling due after the FDF bit is not checked; decoding stops at FDF.

Test Plan:
- 11 recessive, then SOF, base ID 0x123, RTR=0, IDE=0, FDF=0 (with the correct stuff bits inserted) -> arb_valid 1 clk after the FDF sp; id=0x00000123, ide=0, rtr=0, edl=0; busy falls.
- 11 recessive, then SOF, ID 0x000 with stuff bits after every 5 dominant, RTR=1, IDE=0, FDF=1 -> id=0, rtr=1, edl=1, stuff_err never asserted.
- SOF followed by 5 dominant, then a 6th dominant in place of the stuff bit -> stuff_err single pulse, no arb_valid, busy=0. The next SOF is ignored until 11 recessive bits are seen.
- Extended frame: base 0x6AB, SRR=1, IDE=1, ext 0x2CDEF, RTR=1, FDF=0 -> id={11'h6AB, 18'h2CDEF}, ide=1, rtr=1, edl=0.
- Only 10 recessive bits, then dominant -> no SOF accepted (busy stays 0). Separately, assert reset mid-BASE_ID -> all outputs 0, state WAIT_IDLE, no arb_valid.
- Same frame as the first case with 0–3 idle clks (sp=0) between sp strobes -> identical outputs, arb_valid still exactly one clk wide.
